// File: rtl/ir_beacon_tx.sv
// ir_beacon_tx: programmable IR beacon transmitter.
// Drives two IR LED channels with a 50% duty square-wave carrier of
// half-period H clocks (H=0 clamped to 1). Configuration arrives through a
// valid/ready handshake into a pending register and is promoted to active
// in IDLE or at a period boundary, so a running half-period is never cut.
// Optional feature macro: IR_TX_BURST_EN (mark/space burst gating).
//
// Handshake: a configuration transfer happens on a rising clk edge where
// cfg_valid && cfg_ready; cfg_ready is high whenever the pending slot is
// empty, and cfg_valid must hold its fields stable until that edge.
module ir_beacon_tx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          DIV_W  = 24,
    parameter int          CNT_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_half_period,
    input  logic [CNT_W-1:0] cfg_mark,
    input  logic [CNT_W-1:0] cfg_space,
    input  logic [1:0]       cfg_chan_mask,
    output logic [1:0]       ir_out,
    output logic             busy,
    output logic             period_tick
);

    // CLK_HZ documents the clock the divider values assume; no logic uses it.
    localparam int unsigned unused_clk_hz = CLK_HZ;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;          // clocks into current half-period
    logic             half_q, half_d;        // 0 = first half, 1 = second half
    logic [1:0]       ir_q, ir_d;
    logic             tick_q, tick_d;
    logic             have_q, have_d;        // an active configuration exists
    logic             pfull_q, pfull_d;      // pending slot occupied
    logic [DIV_W-1:0] pend_h_q, pend_h_d;
    logic [1:0]       pend_mask_q, pend_mask_d;
    logic [DIV_W-1:0] act_h_q, act_h_d;
    logic [1:0]       act_mask_q, act_mask_d;

`ifdef IR_TX_BURST_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] per_q, per_d;          // whole periods in current state
    logic [CNT_W-1:0] pend_mark_q, pend_mark_d;
    logic [CNT_W-1:0] pend_space_q, pend_space_d;
    logic [CNT_W-1:0] act_mark_q, act_mark_d;
    logic [CNT_W-1:0] act_space_q, act_space_d;
    logic             burst_on;
    assign burst_on = (act_mark_q != '0) && (act_space_q != '0);
`else
    // Mark/space fields are accepted but have no effect without bursts.
    logic unused_cfg;
    assign unused_cfg = ^{cfg_mark, cfg_space};
`endif

    logic [DIV_W-1:0] h_eff;
    logic             div_last;
    logic             boundary;
    logic             promote;
    logic [1:0]       mask_nx;

    assign h_eff    = (act_h_q == '0) ? DIV_ONE : act_h_q;
    assign div_last = (div_q == (h_eff - DIV_ONE));
    // Last cycle of a carrier period or of a silent period.
    assign boundary = (state_q != ST_IDLE) && half_q && div_last;
    assign promote  = pfull_q && ((state_q == ST_IDLE) || boundary);
    // Mask in force from the next cycle, including a same-edge promotion.
    assign mask_nx  = promote ? pend_mask_q : act_mask_q;

    assign cfg_ready   = !pfull_q;
    assign ir_out      = ir_q;
    assign busy        = (state_q != ST_IDLE);
    assign period_tick = tick_q;

    // Next-state, carrier phase and configuration promotion/capture.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        half_d      = half_q;
        ir_d        = ir_q;
        tick_d      = 1'b0;
        have_d      = have_q;
        pfull_d     = pfull_q;
        pend_h_d    = pend_h_q;
        pend_mask_d = pend_mask_q;
        act_h_d     = act_h_q;
        act_mask_d  = act_mask_q;
`ifdef IR_TX_BURST_EN
        per_d        = per_q;
        pend_mark_d  = pend_mark_q;
        pend_space_d = pend_space_q;
        act_mark_d   = act_mark_q;
        act_space_d  = act_space_q;
`endif

        case (state_q)
            ST_IDLE: begin
                ir_d   = 2'b00;
                div_d  = '0;
                half_d = 1'b0;
`ifdef IR_TX_BURST_EN
                per_d  = '0;
`endif
                if (have_q && enable) begin
                    state_d = ST_MARK;
                    ir_d    = mask_nx;
                    tick_d  = 1'b1;
                end
            end

            ST_MARK: begin
                if (!boundary) begin
                    if (div_last) begin
                        div_d  = '0;
                        half_d = 1'b1;
                        ir_d   = 2'b00;
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end else if (!enable) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    half_d  = 1'b0;
                    ir_d    = 2'b00;
`ifdef IR_TX_BURST_EN
                    per_d   = '0;
`endif
                end else begin
                    div_d  = '0;
                    half_d = 1'b0;
`ifdef IR_TX_BURST_EN
                    if (burst_on && (per_q == (act_mark_q - CNT_ONE))) begin
                        state_d = ST_SPACE;
                        per_d   = '0;
                        ir_d    = 2'b00;
                    end else begin
                        per_d  = burst_on ? (per_q + CNT_ONE) : '0;
                        ir_d   = mask_nx;
                        tick_d = 1'b1;
                    end
`else
                    ir_d   = mask_nx;
                    tick_d = 1'b1;
`endif
                end
            end

`ifdef IR_TX_BURST_EN
            ST_SPACE: begin
                ir_d = 2'b00;
                if (!boundary) begin
                    if (div_last) begin
                        div_d  = '0;
                        half_d = 1'b1;
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end else if (!enable) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    half_d  = 1'b0;
                    per_d   = '0;
                end else begin
                    div_d  = '0;
                    half_d = 1'b0;
                    if ((act_space_q == '0) || (per_q == (act_space_q - CNT_ONE))) begin
                        state_d = ST_MARK;
                        per_d   = '0;
                        ir_d    = mask_nx;
                        tick_d  = 1'b1;
                    end else begin
                        per_d = per_q + CNT_ONE;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                half_d  = 1'b0;
                ir_d    = 2'b00;
`ifdef IR_TX_BURST_EN
                per_d   = '0;
`endif
            end
        endcase

        if (promote) begin
            have_d     = 1'b1;
            pfull_d    = 1'b0;
            act_h_d    = pend_h_q;
            act_mask_d = pend_mask_q;
`ifdef IR_TX_BURST_EN
            act_mark_d  = pend_mark_q;
            act_space_d = pend_space_q;
`endif
        end

        if (cfg_valid && !pfull_q) begin
            pfull_d     = 1'b1;
            pend_h_d    = cfg_half_period;
            pend_mask_d = cfg_chan_mask;
`ifdef IR_TX_BURST_EN
            pend_mark_d  = cfg_mark;
            pend_space_d = cfg_space;
`endif
        end
    end

    // State and configuration registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            half_q      <= 1'b0;
            ir_q        <= 2'b00;
            tick_q      <= 1'b0;
            have_q      <= 1'b0;
            pfull_q     <= 1'b0;
            pend_h_q    <= '0;
            pend_mask_q <= 2'b00;
            act_h_q     <= '0;
            act_mask_q  <= 2'b00;
`ifdef IR_TX_BURST_EN
            per_q        <= '0;
            pend_mark_q  <= '0;
            pend_space_q <= '0;
            act_mark_q   <= '0;
            act_space_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            half_q      <= half_d;
            ir_q        <= ir_d;
            tick_q      <= tick_d;
            have_q      <= have_d;
            pfull_q     <= pfull_d;
            pend_h_q    <= pend_h_d;
            pend_mask_q <= pend_mask_d;
            act_h_q     <= act_h_d;
            act_mask_q  <= act_mask_d;
`ifdef IR_TX_BURST_EN
            per_q        <= per_d;
            pend_mark_q  <= pend_mark_d;
            pend_space_q <= pend_space_d;
            act_mark_q   <= act_mark_d;
            act_space_q  <= act_space_d;
`endif
        end
    end

endmodule
